// File: rtl/interleaver_pkg.sv
// Shared definitions for the turbo interleaver blocks.
//   - perm_state_e : permuter FSM encoding (LOAD=0, PERMUTE=1)
//   - DEFAULT_MAX_K: default block buffer depth
//   - alu_op_e     : ALU opcodes used by the QPP index generator
//   - perm_side_t  : sideband registered alongside each permuted sample
package interleaver_pkg;

  typedef enum logic {
    LOAD    = 1'b0,
    PERMUTE = 1'b1
  } perm_state_e;

  localparam int DEFAULT_MAX_K = 6144;

  typedef enum logic [1:0] {
    ALU_SUM  = 2'd0,
    ALU_MULT = 2'd1,
    ALU_DIV  = 2'd2
  } alu_op_e;

  typedef struct packed {
    logic user;
    logic last;
    logic oor;   // index was out of range; sample is forced to zero
  } perm_side_t;

endpackage

// File: rtl/permuter_ram.sv
// Simple dual-port sample buffer: one write port, one read port with a
// registered (1-cycle) output. Kept free of reset and byte enables so it
// maps onto block RAM or can be swapped for a vendor macro.
//   aclk        : clock
//   we/waddr/wdata : write port
//   re/raddr    : read enable/address; rdata updates the cycle after re
//   rdata       : registered read data, held while re is low
module permuter_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 6144,
  parameter int AW    = 13
)(
  input  logic             aclk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge aclk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/interleaver_permuter.sv
// Block interleaver: buffers one block of samples in natural order (length
// taken from s_axis_data_tlast), then emits out[i] = data[ind[i]] driven by
// the QPP index stream.
//   s_axis_data_* : natural-order samples, accepted only in LOAD
//   s_axis_ind_*  : read indices (tuser = first, tlast = last), PERMUTE only
//   m_axis_data_* : permuted samples, tuser/tlast copied from the index
//   o_err_index   : 1-cycle pulse, index >= block length (sample sent as 0)
//   o_err_len     : 1-cycle pulse, buffer overflow or index-count mismatch
//   o_err_cnt     : saturating error-pulse count, only when
//                   INTERLEAVER_PERMUTER_ERR_CNT_EN is defined
module interleaver_permuter
  import interleaver_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int SAMPLE_WIDTH = 8,
  parameter int MAX_K        = DEFAULT_MAX_K,
  parameter int ADDR_WIDTH   = 13
)(
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [SAMPLE_WIDTH-1:0] s_axis_data_tdata,
  input  logic                    s_axis_data_tvalid,
  output logic                    s_axis_data_tready,
  input  logic                    s_axis_data_tlast,
  input  logic [DATA_WIDTH-1:0]   s_axis_ind_tdata,
  input  logic                    s_axis_ind_tvalid,
  output logic                    s_axis_ind_tready,
  input  logic                    s_axis_ind_tuser,
  input  logic                    s_axis_ind_tlast,
  output logic [SAMPLE_WIDTH-1:0] m_axis_data_tdata,
  output logic                    m_axis_data_tvalid,
  input  logic                    m_axis_data_tready,
  output logic                    m_axis_data_tuser,
  output logic                    m_axis_data_tlast,
  output logic                    o_err_index,
  output logic                    o_err_len
`ifdef INTERLEAVER_PERMUTER_ERR_CNT_EN
  ,
  output logic [15:0]             o_err_cnt
`endif
);

  // Counters one bit wider than the address so k_len can hold MAX_K itself.
  localparam int CW = ADDR_WIDTH + 1;

  perm_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q;
  logic [CW-1:0]           rd_cnt_q, k_len_q;
  logic                    rst_done_q;
  logic                    m_vld_q;
  perm_side_t              side_q;
  logic                    err_idx_q, err_len_q;
  logic [SAMPLE_WIDTH-1:0] ram_rdata;

  logic d_hs, at_end, ld_end, ovf, i_hs, i_oor, i_len_err;

  // tready is held low for the first cycle after reset release.
  assign s_axis_data_tready = (state_q == LOAD) && rst_done_q;
  assign s_axis_ind_tready  = (state_q == PERMUTE) && (!m_vld_q || m_axis_data_tready);

  assign d_hs   = s_axis_data_tvalid && s_axis_data_tready;
  assign at_end = (wr_ptr_q == ADDR_WIDTH'(MAX_K - 1));
  assign ld_end = d_hs && (s_axis_data_tlast || at_end);
  assign ovf    = at_end && !s_axis_data_tlast;

  assign i_hs      = s_axis_ind_tvalid && s_axis_ind_tready;
  assign i_oor     = s_axis_ind_tdata >= DATA_WIDTH'(k_len_q);
  assign i_len_err = (s_axis_ind_tuser && (rd_cnt_q != '0)) ||
                     (s_axis_ind_tlast && ((rd_cnt_q + CW'(1)) != k_len_q));

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (ld_end) state_d = PERMUTE;
      PERMUTE: if (i_hs && s_axis_ind_tlast) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= LOAD;
      rst_done_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_cnt_q   <= '0;
      k_len_q    <= '0;
      m_vld_q    <= 1'b0;
      side_q     <= '0;
      err_idx_q  <= 1'b0;
      err_len_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_done_q <= 1'b1;
      err_idx_q  <= 1'b0;
      err_len_q  <= 1'b0;
      // d_hs and i_hs never coincide: they are gated by opposite states.
      if (d_hs) begin
        if (ld_end) begin
          k_len_q   <= CW'(wr_ptr_q) + CW'(1);
          wr_ptr_q  <= '0;
          err_len_q <= ovf;
        end else begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
        end
      end
      if (i_hs) begin
        m_vld_q   <= 1'b1;
        side_q    <= '{user: s_axis_ind_tuser, last: s_axis_ind_tlast, oor: i_oor};
        err_idx_q <= i_oor;
        err_len_q <= i_len_err;
        rd_cnt_q  <= s_axis_ind_tlast ? '0 : rd_cnt_q + CW'(1);
      end else if (m_axis_data_tready) begin
        m_vld_q <= 1'b0;
      end
    end
  end

  // The RAM read register is not reset; masking with valid keeps outputs at
  // zero in reset and between samples. Reads only fire on an index
  // handshake, so rdata holds for the whole of a stall.
  permuter_ram #(
    .WIDTH (SAMPLE_WIDTH),
    .DEPTH (MAX_K),
    .AW    (ADDR_WIDTH)
  ) u_ram (
    .aclk  (aclk),
    .we    (d_hs),
    .waddr (wr_ptr_q),
    .wdata (s_axis_data_tdata),
    .re    (i_hs),
    .raddr (s_axis_ind_tdata[ADDR_WIDTH-1:0]),
    .rdata (ram_rdata)
  );

  assign m_axis_data_tvalid = m_vld_q;
  assign m_axis_data_tdata  = (m_vld_q && !side_q.oor) ? ram_rdata : '0;
  assign m_axis_data_tuser  = m_vld_q && side_q.user;
  assign m_axis_data_tlast  = m_vld_q && side_q.last;
  assign o_err_index        = err_idx_q;
  assign o_err_len          = err_len_q;

`ifdef INTERLEAVER_PERMUTER_ERR_CNT_EN
  // Both pulses in one cycle add 2; clamps at all-ones.
  logic [16:0] cnt_sum;
  assign cnt_sum = {1'b0, o_err_cnt} + 17'(err_idx_q) + 17'(err_len_q);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) o_err_cnt <= '0;
    else          o_err_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end
`endif

endmodule

// File: doc/interleaver_permuter.md
Name: interleaver_permuter

Overview:
- Downstream consumer of the QPP index generator's m_axis_ind stream. Buffers one block of K samples in natural order, then emits them in interleaved order: out[i] = data[ind[i]].
- Block length K comes from the input tlast, not from a separate K port.
- Sits between the encoder input framing and the second constituent encoder.

Parameters:
- DATA_WIDTH, 32, width of the index tdata; matches the generator's index width.
- SAMPLE_WIDTH, 8, width of one data sample.
- MAX_K, 6144, buffer depth in samples.
- ADDR_WIDTH, 13, buffer address width; must satisfy 2^ADDR_WIDTH >= MAX_K.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_axis_data_tdata  in  SAMPLE_WIDTH  natural-order sample
- s_axis_data_tvalid  in  1  sample valid
- s_axis_data_tready  out  1  ready; high only in LOAD
- s_axis_data_tlast  in  1  last sample of the block
- s_axis_ind_tdata  in  DATA_WIDTH  interleaved read index
- s_axis_ind_tvalid  in  1  index valid
- s_axis_ind_tready  out  1  index ready
- s_axis_ind_tuser  in  1  first index of the vector
- s_axis_ind_tlast  in  1  last index of the vector
- m_axis_data_tdata  out  SAMPLE_WIDTH  permuted sample
- m_axis_data_tvalid  out  1  output valid
- m_axis_data_tready  in  1  downstream ready
- m_axis_data_tuser  out  1  copy of the index tuser
- m_axis_data_tlast  out  1  copy of the index tlast
- o_err_index  out  1  1-cycle pulse: index >= k_len
- o_err_len  out  1  1-cycle pulse: block length or index-count error

Behaviour:
- Reset: asynchronous, active-low. While asserted:
  - state=LOAD; wr_ptr=0, rd_cnt=0, k_len=0;
  - every output = 0, except s_axis_data_tready=1 one cycle after deassertion.
  - Buffer RAM contents are not reset.
  - Reset mid-block discards the partial block; no output is produced for it.
- FSM states: LOAD, PERMUTE.
- LOAD:
  - s_axis_data_tready=1, s_axis_ind_tready=0.
  - Each data handshake writes mem[wr_ptr] and increments wr_ptr.
  - A handshake with tlast=1 sets k_len=wr_ptr+1 and moves to PERMUTE next cycle.
  - Overflow: a handshake at wr_ptr=MAX_K-1 without tlast is treated as last (k_len=MAX_K) and pulses o_err_len.
- PERMUTE:
  - s_axis_data_tready=0.
  - s_axis_ind_tready = !m_axis_data_tvalid || m_axis_data_tready (combinational).
  - On an index handshake:
    - synchronous RAM read of mem[ind[ADDR_WIDTH-1:0]];
    - m_axis_data_tvalid=1 on the next cycle, with tuser/tlast registered alongside;
    - rd_cnt increments.
  - Latency: 1 cycle from index handshake to output valid. Throughput: 1 sample/cycle when downstream is always ready.
- Output hold: while m_axis_data_tvalid && !m_axis_data_tready, all output fields hold and no RAM read occurs.
- Output valid clears when a handshake completes with no new index accepted in the same cycle.
- Index out of range (ind >= k_len): output tdata=0, o_err_index pulses in the same cycle the output becomes valid, and the stream continues.
- Block end: index handshake with tlast=1 → state returns to LOAD next cycle; wr_ptr=0, rd_cnt=0.
  - If rd_cnt+1 != k_len at that handshake, pulse o_err_len.
  - The pending output sample remains valid and drains normally. A new load may overlap the drain because the output is registered.
- Index tuser with rd_cnt != 0: pulse o_err_len; tuser is still passed through.
- rd_cnt reaching k_len without tlast: no auto-termination; further indices are still served; the end-of-block check fires at tlast.
- Simultaneous events: an output handshake and a new index handshake in the same cycle produce back-to-back outputs with no bubble.

Optional Feature:
- Macro: INTERLEAVER_PERMUTER_ERR_CNT_EN.
- Defined: adds output port o_err_cnt [15:0], a saturating count of o_err_index and o_err_len pulses (both in one cycle count as 2). Cleared only by reset.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Shared package interleaver_pkg:
  - permuter state encoding (LOAD=0, PERMUTE=1);
  - default MAX_K=6144;
  - the ALU opcode constants already used by the generator (SUM, MULT, DIV), kept in one place.
- One sub-module: permuter_ram, a simple dual-port RAM, SAMPLE_WIDTH x MAX_K, with 1 write port and a 1-cycle registered read port, so the RAM is inferable/replaceable.

Test Plan:
- Basic permute: load K=40 samples data[n]=n+0x10 with tlast on n=39; feed QPP indices for f1=3, f2=10 (0,13,6,19,...). Expect outputs 0x10,0x1D,0x16,0x23,...; tuser on the first output, tlast on the 40th; no error pulses.
- Backpressure: same block with m_axis_data_tready toggling 1,0,0,1. Expect tdata/tuser/tlast stable while stalled, s_axis_ind_tready=0 during stalls, and exactly 40 outputs.
- Out-of-range index: K=8, index stream includes 9. Expect output tdata=0 for that slot, a single o_err_index pulse, and the remaining samples correct.
- Length mismatch: K=8, index tlast arrives on the 6th index. Expect o_err_len pulse, return to LOAD, and a following K=4 block permuted correctly.
- Overflow: MAX_K=16 build, send 20 samples without tlast. Expect o_err_len on the 16th sample, k_len=16, s_axis_data_tready=0 from the next cycle.
- Reset mid-PERMUTE after 3 of 40 outputs. Expect all outputs 0 immediately; after release s_axis_data_tready=1; a new K=40 block works correctly.
